// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// rr_next() is written for up to NREQ_MAX requesters; callers zero-extend into it.
package rr_arb_pkg;

    localparam int unsigned NREQ_MAX   = 16;
    localparam int unsigned IDXW       = $clog2(NREQ_MAX);
    localparam int unsigned N_REQ_DFLT = 4;
    localparam int unsigned DW_DFLT    = 8;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    // First set bit of req searching ptr+1, ptr+2, ... modulo n; returns ptr when req is empty.
    function automatic logic [IDXW-1:0] rr_next(input logic [NREQ_MAX-1:0] req,
                                                 input logic [IDXW-1:0]     ptr,
                                                 input int                  n);
        logic [IDXW-1:0] idx;
        logic            found;
        int              s;
        idx   = ptr;
        found = 1'b0;
        for (int k = 1; k <= int'(NREQ_MAX); k++) begin
            s = int'(ptr) + k;
            if (s >= n) s = s - n;
            if (k <= n && !found && req[s[IDXW-1:0]]) begin
                idx   = s[IDXW-1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// Requester-side bus of the round-robin shared-register arbiter.
// master = requester/producer side, slave = the arbiter.
interface rr_reg_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8
);
    localparam int unsigned IdxW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] wdata;
    logic                lock;
    logic [N_REQ-1:0]    gnt;
    logic [DW-1:0]       q;
    logic                q_valid;
    logic [IdxW-1:0]     q_src;
    logic                busy;

    modport master (
        output req, wdata, lock,
        input  gnt, q, q_valid, q_src, busy
    );

    modport slave (
        input  req, wdata, lock,
        output gnt, q, q_valid, q_src, busy
    );

endinterface

// File: rtl/rr_reg_arbiter_pick.sv
// Combinational masked round-robin picker: one-hot pick and index of the next
// requester after ptr among the already-masked request vector.
module rr_pick import rr_arb_pkg::*; #(
    parameter int unsigned N_REQ = N_REQ_DFLT,
    localparam int unsigned IdxW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_eff,
    input  logic [IdxW-1:0]  ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IdxW-1:0]  idx,
    output logic             any
);

    logic [IDXW-1:0] nxt;
    logic            unused_nxt;

    always_comb begin
        nxt  = rr_next(NREQ_MAX'(req_eff), IDXW'(ptr), int'(N_REQ));
        any  = |req_eff;
        idx  = nxt[IdxW-1:0];
        pick = '0;
        if (any) pick[idx] = 1'b1;
    end

    // Upper index bits are always zero for N_REQ below NREQ_MAX.
    assign unused_nxt = ^nxt;

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one DW-bit holding register between N_REQ requesters.
// Optional RR_ARB_LOCK_EN: lock=1 in GRANT holds the current winner and recaptures its lane.
module rr_reg_arbiter import rr_arb_pkg::*; #(
    parameter int unsigned N_REQ = N_REQ_DFLT,
    parameter int unsigned DW    = DW_DFLT
) (
    input logic             clk,
    input logic             rst_n,
    rr_reg_arbiter_if.slave bus
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IdxW-1:0]  ptr_q;
    logic [DW-1:0]    q_q;
    logic [IdxW-1:0]  q_src_q;
    logic             q_valid_q;

    logic [N_REQ-1:0] req_eff;
    logic [N_REQ-1:0] pick;
    logic [IdxW-1:0]  pick_idx;
    logic             pick_any;
    logic             hold;
    logic [DW-1:0]    lane_sel;

    // The current winner is masked so a still-held request is not granted twice.
    assign req_eff = bus.req & ~gnt_q;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req_eff(req_eff),
        .ptr    (ptr_q),
        .pick   (pick),
        .idx    (pick_idx),
        .any    (pick_any)
    );

`ifdef RR_ARB_LOCK_EN
    assign hold = (state_q == StGrant) && bus.lock;
`else
    logic unused_lock;
    assign unused_lock = bus.lock;
    assign hold        = 1'b0;
`endif

    // ptr_q always equals the index of the live grant, so it selects the lane to capture.
    always_comb begin
        lane_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (ptr_q == IdxW'(i)) lane_sel = bus.wdata[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            ptr_q     <= IdxW'(N_REQ - 1);
            q_q       <= '0;
            q_src_q   <= '0;
            q_valid_q <= 1'b0;
        end else begin
            if (|gnt_q) begin
                q_q       <= lane_sel;
                q_src_q   <= ptr_q;
                q_valid_q <= 1'b1;
            end else begin
                q_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        state_q <= StGrant;
                        gnt_q   <= pick;
                        ptr_q   <= pick_idx;
                    end
                end
                StGrant: begin
                    if (!hold) begin
                        if (pick_any) begin
                            gnt_q <= pick;
                            ptr_q <= pick_idx;
                        end else begin
                            state_q <= StIdle;
                            gnt_q   <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.q_src   = q_src_q;
    assign bus.busy    = (state_q == StGrant);

endmodule
